// File: rtl/gray_seq_ctrl.sv
// Prescaled up/down binary counter with a registered Gray-code mirror, sequenced by
// a three-state IDLE/RUN/DONE controller that supports free-run and single-sweep modes.
module gray_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [3:0]       step_div,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic [3:0]       presc_q, presc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             wrap_q, wrap_d;
    logic             wrap_tick_s;

    // Next-state, counter and pulse logic; stop outranks load, load outranks a tick.
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        presc_d     = presc_q;
        wrap_d      = 1'b0;
        wrap_tick_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    bin_d   = load_val;
                    presc_d = 4'd0;
                end else if (start && !stop) begin
                    state_d = ST_RUN;
                    presc_d = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    presc_d = 4'd0;
                end else if (load) begin
                    bin_d   = load_val;
                    presc_d = 4'd0;
                end else if (presc_q == step_div) begin
                    presc_d     = 4'd0;
                    bin_d       = dir ? (bin_q + ONE) : (bin_q - ONE);
                    wrap_tick_s = dir ? (bin_q == ALL_ONES) : (bin_q == ZERO);
                    wrap_d      = wrap_tick_s;
                    if (wrap_tick_s && mode) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    presc_d = presc_q + 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (load) begin
                    bin_d   = load_val;
                    presc_d = 4'd0;
                end else begin
                    presc_d = presc_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                presc_d = 4'd0;
            end
        endcase
        // Outputs are computed from the next state so they register with zero skew.
        gray_d = to_gray(bin_d);
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State, counter and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bin_q   <= ZERO;
            gray_q  <= ZERO;
            presc_q <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            presc_q <= presc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bin  = bin_q;
    assign gray = gray_q;
    assign busy = busy_q;
    assign done = done_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Directed bench for gray_seq_ctrl (WIDTH=4): Gray sequence, single sweep, load/stop
// priority, start+stop in IDLE, asynchronous reset and a pseudo-random one-bit-change run.
module tb_gray_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       dir;
    logic       mode;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] step_div;
    logic [3:0] bin;
    logic [3:0] gray;
    logic       busy;
    logic       done;
    logic       wrap;

    int n_checks = 0;
    int n_errors = 0;

    gray_seq_ctrl #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .dir      (dir),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .step_div (step_div),
        .bin      (bin),
        .gray     (gray),
        .busy     (busy),
        .done     (done),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] gseq [16];
        logic [3:0] bseq [4];
        logic [3:0] prev_g;
        logic       ld;

        gseq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
        bseq = '{4'h2, 4'h1, 4'h0, 4'hF};

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b1; mode = 1'b0;
        load = 1'b0; load_val = 4'h0; step_div = 4'd0;
        #3;
        chk("rst_bin", 16'(bin), 16'h0);
        chk("rst_gray", 16'(gray), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_done", 16'(done), 16'h0);
        chk("rst_wrap", 16'(wrap), 16'h0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Free-running up count: full Gray sequence with one wrap pulse
        start = 1'b1;
        step();
        start = 1'b0;
        chk("a_busy0", 16'(busy), 16'h1);
        chk("a_gray0", 16'(gray), 16'h0);
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("a_gray", 16'(gray), 16'(gseq[i % 16]));
            chk("a_busy", 16'(busy), 16'h1);
            chk("a_wrap", 16'(wrap), (i == 16) ? 16'h1 : 16'h0);
            chk("a_done", 16'(done), 16'h0);
        end
        step();
        chk("a_gray_after", 16'(gray), 16'h1);
        chk("a_wrap_after", 16'(wrap), 16'h0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("a_stop_busy", 16'(busy), 16'h0);
        chk("a_stop_bin", 16'(bin), 16'h1);

        // Single down sweep from 3 with step_div=2
        load = 1'b1; load_val = 4'h3; dir = 1'b0; mode = 1'b1; step_div = 4'd2;
        step();
        load = 1'b0;
        chk("b_load_bin", 16'(bin), 16'h3);
        chk("b_load_busy", 16'(busy), 16'h0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("b_run_busy", 16'(busy), 16'h1);
        prev_g = 4'h3;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("b_hold1", 16'(bin), 16'(prev_g));
            step();
            chk("b_hold2", 16'(bin), 16'(prev_g));
            step();
            chk("b_tick", 16'(bin), 16'(bseq[k]));
            prev_g = bseq[k];
        end
        chk("b_done", 16'(done), 16'h1);
        chk("b_done_busy", 16'(busy), 16'h0);
        chk("b_done_wrap", 16'(wrap), 16'h1);
        chk("b_done_gray", 16'(gray), 16'h8);
        step();
        chk("b_post_done", 16'(done), 16'h0);
        chk("b_post_busy", 16'(busy), 16'h0);
        chk("b_post_wrap", 16'(wrap), 16'h0);
        chk("b_post_bin", 16'(bin), 16'hF);
        step();
        chk("b_hold_bin", 16'(bin), 16'hF);

        // Load on a tick cycle suppresses the tick; stop one cycle later
        load = 1'b1; load_val = 4'h5; dir = 1'b1; mode = 1'b0; step_div = 4'd0;
        step();
        load = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        chk("c_bin5", 16'(bin), 16'h5);
        load = 1'b1; load_val = 4'hA;
        step();
        load = 1'b0; stop = 1'b1;
        chk("c_load_bin", 16'(bin), 16'hA);
        chk("c_load_gray", 16'(gray), 16'hF);
        chk("c_load_wrap", 16'(wrap), 16'h0);
        chk("c_load_busy", 16'(busy), 16'h1);
        step();
        stop = 1'b0;
        chk("c_stop_busy", 16'(busy), 16'h0);
        chk("c_stop_bin", 16'(bin), 16'hA);
        step();
        chk("c_idle_bin", 16'(bin), 16'hA);

        // start and stop together in IDLE are ignored
        start = 1'b1; stop = 1'b1;
        step();
        chk("d_busy", 16'(busy), 16'h0);
        chk("d_bin", 16'(bin), 16'hA);
        step();
        start = 1'b0; stop = 1'b0;
        chk("d_busy2", 16'(busy), 16'h0);
        chk("d_gray", 16'(gray), 16'hF);

        // Asynchronous reset in the middle of a run
        load = 1'b1; load_val = 4'h9; step_div = 4'd15;
        step();
        load = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        chk("e_bin9", 16'(bin), 16'h9);
        chk("e_busy", 16'(busy), 16'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("e_rst_bin", 16'(bin), 16'h0);
        chk("e_rst_gray", 16'(gray), 16'h0);
        chk("e_rst_busy", 16'(busy), 16'h0);
        chk("e_rst_done", 16'(done), 16'h0);
        chk("e_rst_wrap", 16'(wrap), 16'h0);
        step();
        rst_n = 1'b1; step_div = 4'd0; dir = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("e_restart_bin", 16'(bin), 16'h0);
        chk("e_restart_busy", 16'(busy), 16'h1);
        step();
        chk("e_cnt1", 16'(bin), 16'h1);
        step();
        chk("e_cnt2", 16'(bin), 16'h2);
        dir = 1'b0;
        step();
        chk("e_dir_flip", 16'(bin), 16'h1);
        chk("e_dir_gray", 16'(gray), 16'h1);
        stop = 1'b1;
        step();
        stop = 1'b0;

        // Pseudo-random run: Gray output changes at most one bit except after loads
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 0; n < 60; n++) begin
            dir      = 1'($urandom_range(0, 1));
            step_div = 4'($urandom_range(0, 3));
            ld       = ($urandom_range(0, 7) == 0);
            load     = ld;
            load_val = 4'($urandom_range(0, 15));
            prev_g   = gray;
            step();
            chk("f_gray_code", 16'(gray), 16'(bin ^ (bin >> 1)));
            if (!ld) begin
                chk("f_one_bit", 16'($countones(prev_g ^ gray) <= 1), 16'h1);
            end else begin
                chk("f_load_bin", 16'(bin), 16'(load_val));
            end
        end
        load = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/gray_seq_ctrl.md
GRAY_SEQ_CTRL -- requirements
Module: gray_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, counter and Gray code width in bits (legal range 2..16).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  begin sequencing; sampled only in IDLE.
REQ-005 stop  input  1  abort sequencing; honoured in RUN.
REQ-006 dir  input  1  1 = count up, 0 = count down; sampled at each tick.
REQ-007 mode  input  1  0 = free-run, 1 = single sweep (stop after one wrap).
REQ-008 load  input  1  load load_val into the binary counter.
REQ-009 load_val  input  WIDTH  preset value for the binary counter.
REQ-010 step_div  input  4  prescaler; counter advances once every step_div+1 cycles in RUN.
REQ-011 bin  output  WIDTH  registered binary count.
REQ-012 gray  output  WIDTH  registered Gray code of bin.
REQ-013 busy  output  1  high while in RUN.
REQ-014 done  output  1  one-cycle pulse on completion of a single sweep.
REQ-015 wrap  output  1  one-cycle pulse on the cycle after the counter wraps.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 IDLE -> RUN SHALL occur on start=1 and stop=0; start with stop both high in IDLE SHALL leave the FSM in IDLE.
REQ-018 RUN -> IDLE SHALL occur on stop=1; bin and gray hold, and the prescaler clears to 0.
REQ-019 RUN -> DONE SHALL occur on a wrapping tick when mode=1; DONE SHALL last exactly one cycle, then return to IDLE.
REQ-020 start in RUN or DONE SHALL be ignored.
REQ-021 In RUN, the internal prescaler presc (4 bits) SHALL increment each cycle. When presc==step_div, a tick occurs and presc returns to 0.
REQ-022 On a tick, bin SHALL become bin+1 when dir=1 and bin-1 when dir=0, modulo 2^WIDTH.
REQ-023 A tick that takes bin from all-ones to 0 (up) or from 0 to all-ones (down) SHALL be a wrapping tick; wrap=1 for the following cycle only.
REQ-024 gray SHALL equal bin XOR (bin >> 1) in every cycle; it is registered alongside bin with zero relative latency.
REQ-025 load=1 SHALL be accepted in any state: next cycle bin=load_val and gray=code(load_val), presc=0, FSM state unchanged.
REQ-026 Priority within RUN SHALL be stop > load > tick; a load coinciding with a tick suppresses the tick and its wrap.
REQ-027 A change of dir in mid-run SHALL take effect at the next tick, with no extra delay.
REQ-028 step_div=0 SHALL produce a tick every RUN cycle; changes to step_div SHALL take effect at the next comparison.
REQ-029 busy SHALL be 1 exactly when the state is RUN; done SHALL be 1 exactly when the state is DONE.
REQ-030 With mode=0, wrapping SHALL continue indefinitely with a wrap pulse per wrap and no done.

Reset
REQ-031 When rst_n=0, the block SHALL immediately force: state=IDLE, bin=0, gray=0, presc=0, busy=0, done=0, wrap=0, independent of clk.
REQ-032 Reset asserted in RUN or DONE SHALL abort with no done or wrap pulse; the block SHALL resume from IDLE on the first edge after rst_n rises.

Verification
REQ-033 WIDTH=4, step_div=0, dir=1, mode=0, start -> gray follows 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0 on successive cycles; wrap pulses after 8->0; busy stays 1.
REQ-034 mode=1, dir=0, load_val=3 loaded, start, step_div=2 -> bin 3,2,1,0,F at ticks 3 cycles apart; FSM enters DONE on the 0->F tick; done=1 for one cycle, then busy=0 and bin holds F.
REQ-035 RUN with bin=5, load=1 with load_val=A on a tick cycle, plus stop one cycle later -> bin=A, gray=F, no tick applied, FSM IDLE, bin holds A.
REQ-036 start and stop both high in IDLE -> FSM stays IDLE, busy=0, bin unchanged.
REQ-037 rst_n low mid-RUN at bin=9 -> bin, gray, busy, done, wrap all 0 before the next clk edge; start after release counts from 0.
REQ-038 Random dir/step_div/load run -> every gray change differs from the previous gray in exactly one bit, except on load cycles.
